rv32_dbus_ctrl: RTL and testbench
=================================

# rv32_dbus_ctrl

Parametrised data-bus controller between the RV32I core's data port and up to NSLV memory-mapped slaves: data RAM, timer, GPIO and UART.
- Decodes each core access against per-slave base/mask regions and drives one active-low chip select.
- Holds the access until the selected slave signals ready, so slaves may insert wait states.
- Converts decode misses and unresponsive slaves into an error response, and keeps error statistics for debug.

## Interface
Parameters:
- NSLV, 4, number of slave ports (1..8)
- DWIDTH, 32, data width; byte lanes = DWIDTH/8
- AWIDTH, 32, address width
- SLV_BASE, {NSLV{32'h0}}, packed NSLV*AWIDTH base addresses; slave i at bits [i*AWIDTH +: AWIDTH]
- SLV_MASK, {NSLV{32'hFFFF_F000}}, packed NSLV*AWIDTH masks; hit(i) = ((m_addr & MASK_i) == BASE_i)
- TIMEOUT, 255, maximum wait cycles in ACCESS before error (1..2^TO_W-1)
- TO_W, 8, timeout counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- m_req  in  1  core access request; sampled only in IDLE
- m_we  in  1  1 = write, 0 = read
- m_addr  in  AWIDTH  byte address
- m_be  in  DWIDTH/8  byte enables
- m_wdata  in  DWIDTH  byte-lane-aligned write data
- m_rdata  out  DWIDTH  read data, valid when m_ready=1
- m_ready  out  1  one-cycle completion pulse
- m_err  out  1  qualifies m_ready: decode miss or timeout
- s_cs_n  out  NSLV  active-low one-hot chip selects
- s_we, s_addr, s_be, s_wdata  out  1/AWIDTH/DWIDTH/8/DWIDTH  registered copies of the captured request
- s_rdata  in  NSLV*DWIDTH  packed slave read data
- s_ready  in  NSLV  slave completion, sampled only for the selected slave
- err_cnt  out  16  saturating count of error responses
- err_addr  out  AWIDTH  address of the most recent error

## Operation
- FSM states:
  - IDLE: m_req=1 and some slave hits → capture request and sel index → ACCESS. m_req=1 with no hit → ERR. Otherwise stay.
  - ACCESS: s_cs_n[sel]=0.
    - s_ready[sel]=1 → latch s_rdata[sel] → RESP.
    - Otherwise, if to_cnt==TIMEOUT-1 → ERR.
    - Otherwise to_cnt++.
  - RESP: m_ready=1, m_err=0 → IDLE.
  - ERR: m_ready=1, m_err=1, m_rdata=0, err_cnt++ (saturating at 16'hFFFF), err_addr←captured address → IDLE.
- Overlapping regions: lowest index wins.
- m_req is ignored outside IDLE. The core holds its request until m_ready; no queuing.
- m_rdata holds its last value except in ERR, where it is forced to 0. On writes it equals the slave read data or is don't-care; the bench does not check it on writes.
- s_ready from non-selected slaves is ignored. s_ready outside ACCESS is ignored.
- Simultaneous s_ready[sel]=1 and timeout on the same cycle: ready wins, no error.
- Reset values: state=IDLE, s_cs_n=all 1, s_we=0, s_addr=0, s_be=0, s_wdata=0, m_rdata=0, m_ready=0, m_err=0, to_cnt=0, err_cnt=0, err_addr=0.
- Reset mid-access: next edge returns to IDLE, deasserts all chip selects, and issues no m_ready for the aborted access.

## Timing
- Edge 0: IDLE samples m_req. From edge 0+ the FSM is in ACCESS and s_* outputs are driven.
- Slave ready at ACCESS cycle k (k=1 is the first ACCESS cycle) → m_ready high for exactly one cycle starting at edge k+1. Zero-wait slave gives 2-cycle latency, request to m_ready.
- Decode miss: m_ready/m_err high in the cycle after the request edge (1-cycle latency).
- Timeout: no ready for TIMEOUT ACCESS cycles → m_ready/m_err high in cycle TIMEOUT+1.
- s_cs_n deasserts on the same edge that enters RESP/ERR. Back-to-back: the next request can be sampled in the cycle after m_ready, so minimum 3 cycles per access.

## Test plan
- Reset check: reset=1 for 2 cycles → all outputs at reset values, s_cs_n=4'b1111, err_cnt=0.
- Zero-wait read: SLV_BASE[0]=0x1000_0000, mask 0xFFFF_F000; read 0x1000_0010 with slave0 ready immediately and s_rdata=0xCAFE_F00D → s_cs_n=4'b1110 for 1 cycle; m_ready at cycle 2 with m_rdata=0xCAFE_F00D, m_err=0.
- Wait states and byte write: write 0x2000_0004 to slave1, m_be=4'b0011, wdata=0x0000_BEEF; slave1 ready after 3 cycles → s_be/s_wdata/s_addr stable for 3 cycles; m_ready at cycle 4, no error.
- Decode miss: read 0xF000_0000 (no hit) → m_ready=1, m_err=1, m_rdata=0 in the next cycle; err_cnt=1; err_addr=0xF000_0000; no chip select asserted.
- Timeout and race: TIMEOUT=4, slave never ready → error at cycle 5, err_cnt increments. Repeat with ready on the 4th ACCESS cycle → m_err=0.
- Reset mid-access: assert reset during the 2nd wait cycle → s_cs_n=all 1 next edge, no m_ready. A following access completes normally.

Source files
------------

// File: rtl/rv32_dbus_ctrl_if.sv
// Data-bus bundle between the RV32I core, the bus controller and its slaves.
// Latency: none, wires only.
// Backpressure: the core holds m_req until m_ready; slaves stall with s_ready low.
//
// Modports:
//   master - the environment side: core request inputs and slave responses
//   slave  - the controller side: serves core requests, drives the slave bus
interface rv32_dbus_ctrl_if #(
  parameter int NSLV   = 4,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  // core side
  logic                     m_req;
  logic                     m_we;
  logic [AWIDTH-1:0]        m_addr;
  logic [DWIDTH/8-1:0]      m_be;
  logic [DWIDTH-1:0]        m_wdata;
  logic [DWIDTH-1:0]        m_rdata;
  logic                     m_ready;
  logic                     m_err;
  // slave side
  logic [NSLV-1:0]          s_cs_n;
  logic                     s_we;
  logic [AWIDTH-1:0]        s_addr;
  logic [DWIDTH/8-1:0]      s_be;
  logic [DWIDTH-1:0]        s_wdata;
  logic [NSLV*DWIDTH-1:0]   s_rdata;
  logic [NSLV-1:0]          s_ready;

  modport master (
    output m_req, m_we, m_addr, m_be, m_wdata, s_rdata, s_ready,
    input  m_rdata, m_ready, m_err, s_cs_n, s_we, s_addr, s_be, s_wdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_be, m_wdata, s_rdata, s_ready,
    output m_rdata, m_ready, m_err, s_cs_n, s_we, s_addr, s_be, s_wdata
  );
endinterface

// File: rtl/rv32_dbus_ctrl.sv
// Data-bus controller: decodes core accesses onto NSLV slaves with one-hot chip selects.
// Latency: 2 cycles request to m_ready for a zero-wait slave, 1 cycle for a decode miss.
// Backpressure: holds the access while s_ready[sel] is low, up to TIMEOUT cycles, then errors.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   bus (slave)   - core request/response and slave chip-select bus
//   err_cnt       - saturating count of error responses
//   err_addr      - address of the most recent error response
module rv32_dbus_ctrl #(
  parameter int                      NSLV     = 4,
  parameter int                      DWIDTH   = 32,
  parameter int                      AWIDTH   = 32,
  parameter logic [NSLV*AWIDTH-1:0]  SLV_BASE = '0,
  parameter logic [NSLV*AWIDTH-1:0]  SLV_MASK = {NSLV{32'hFFFF_F000}},
  parameter int                      TIMEOUT  = 255,
  parameter int                      TO_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  rv32_dbus_ctrl_if.slave   bus,
  output logic [15:0]       err_cnt,
  output logic [AWIDTH-1:0] err_addr
);

  localparam int BW    = DWIDTH / 8;
  localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [BW-1:0]       be_q, be_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [AWIDTH-1:0]   err_addr_q, err_addr_d;

  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic                sel_ready;
  logic [DWIDTH-1:0]   sel_rdata;

  // Address decode. Scanning from the top index down lets the lowest
  // matching index overwrite the result, so overlapping regions resolve
  // to the lowest slave number.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((bus.m_addr & SLV_MASK[i*AWIDTH +: AWIDTH]) == SLV_BASE[i*AWIDTH +: AWIDTH]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Only the selected slave's response is ever looked at.
  assign sel_ready = bus.s_ready[sel_q];
  assign sel_rdata = bus.s_rdata[sel_q*DWIDTH +: DWIDTH];

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    to_cnt_d   = to_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (bus.m_req) begin
          // Capture even on a miss so the error path can report the address.
          we_d    = bus.m_we;
          addr_d  = bus.m_addr;
          be_d    = bus.m_be;
          wdata_d = bus.m_wdata;
          if (hit) begin
            sel_d   = hit_idx;
            state_d = ACCESS;
          end else begin
            rdata_d = '0;
            state_d = ERR;
          end
        end
      end

      ACCESS: begin
        // Ready is tested before the timeout so a same-cycle race completes cleanly.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end else if (to_cnt_q == TO_LAST) begin
          rdata_d = '0;
          state_d = ERR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      ERR: begin
        if (err_cnt_q != 16'hFFFF) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
        err_addr_d = addr_q;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      to_cnt_q   <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      to_cnt_q   <= to_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Outputs decode straight from registered state, so chip selects drop
  // on the same edge that enters RESP or ERR.
  always_comb begin
    bus.s_cs_n = '1;
    if (state_q == ACCESS) begin
      bus.s_cs_n[sel_q] = 1'b0;
    end
  end

  assign bus.m_ready = (state_q == RESP) || (state_q == ERR);
  assign bus.m_err   = (state_q == ERR);
  assign bus.m_rdata = rdata_q;
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_be    = be_q;
  assign bus.s_wdata = wdata_q;
  assign err_cnt     = err_cnt_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_rv32_dbus_ctrl.sv
module tb_rv32_dbus_ctrl;

  localparam logic [127:0] BASES = {32'h1000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
  // Slave 3 covers 0x1xxx_xxxx and so overlaps slave 0's 4 KiB window.
  localparam logic [127:0] MASKS = {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic        clk;
  logic        reset;
  logic [15:0] err_cnt;
  logic [31:0] err_addr;

  rv32_dbus_ctrl_if #(.NSLV(4), .DWIDTH(32), .AWIDTH(32)) bus ();

  rv32_dbus_ctrl #(
    .NSLV(4), .DWIDTH(32), .AWIDTH(32),
    .SLV_BASE(BASES), .SLV_MASK(MASKS),
    .TIMEOUT(4), .TO_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .err_cnt  (err_cnt),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          rdy_cyc;   // ACCESS cycle in which the slave answers, 0 = never
    int          sel;       // expected slave, -1 = decode miss
    int          lat;       // cycles from request edge to m_ready
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [9];
  int          total;
  int          bad;
  int          model_cnt;
  logic [31:0] model_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         c;
    bit         done;
    int         cs_bad;
    int         bus_bad;
    logic [3:0] exp_cs;
    bus.m_req   = 1'b1;
    bus.m_we    = v.we;
    bus.m_addr  = v.addr;
    bus.m_be    = v.be;
    bus.m_wdata = v.wdata;
    if (v.sel >= 0) bus.s_ready[v.sel] = 1'b0;
    c       = 0;
    done    = 1'b0;
    cs_bad  = 0;
    bus_bad = 0;
    while (!done && c < 20) begin
      @(negedge clk);
      c++;
      if (bus.m_ready === 1'b1) done = 1'b1;
      exp_cs = (!done && v.sel >= 0) ? ~(4'b0001 << v.sel) : 4'hF;
      if (bus.s_cs_n !== exp_cs) cs_bad++;
      if (!done && v.sel >= 0) begin
        if (bus.s_addr !== v.addr || bus.s_we !== v.we ||
            bus.s_be !== v.be || bus.s_wdata !== v.wdata) bus_bad++;
        bus.s_ready[v.sel] = (c == v.rdy_cyc);
      end
    end
    check($sformatf("v%0d done", idx), 32'(done), 32'd1);
    check($sformatf("v%0d latency", idx), 32'(c), 32'(v.lat));
    check($sformatf("v%0d m_err", idx), 32'(bus.m_err), 32'(v.err));
    if (!v.we || v.err) check($sformatf("v%0d m_rdata", idx), bus.m_rdata, v.rdata);
    check($sformatf("v%0d cs_bad", idx), 32'(cs_bad), 32'd0);
    check($sformatf("v%0d bus_bad", idx), 32'(bus_bad), 32'd0);
    bus.m_req   = 1'b0;
    bus.s_ready = 4'hF;
    if (v.err) begin
      model_cnt++;
      model_addr = v.addr;
    end
    @(negedge clk);
    check($sformatf("v%0d pulse", idx), 32'(bus.m_ready), 32'd0);
    check($sformatf("v%0d err_cnt", idx), 32'(err_cnt), 32'(model_cnt));
    check($sformatf("v%0d err_addr", idx), err_addr, model_addr);
  endtask

  initial begin
    int pulses;
    total      = 0;
    bad        = 0;
    model_cnt  = 0;
    model_addr = 32'h0;

    //            we    addr          be     wdata         rdy sel lat err rdata
    vecs[0] = '{1'b0, 32'h1000_0010, 4'hF, 32'h0,         1,  0,  2, 1'b0, 32'hCAFE_F00D};
    vecs[1] = '{1'b1, 32'h2000_0004, 4'h3, 32'h0000_BEEF, 3,  1,  4, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'hF000_0000, 4'hF, 32'h0,         0, -1,  1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h3000_0100, 4'hF, 32'h0,         0,  2,  5, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h3000_0104, 4'hF, 32'h0,         4,  2,  5, 1'b0, 32'h2222_2222};
    vecs[5] = '{1'b0, 32'h1000_5000, 4'hF, 32'h0,         2,  3,  3, 1'b0, 32'h3333_3333};
    vecs[6] = '{1'b1, 32'h1000_0FFC, 4'h8, 32'hAB00_0000, 1,  0,  2, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h1000_1000, 4'hF, 32'h0,         1,  3,  2, 1'b0, 32'h3333_3333};
    vecs[8] = '{1'b0, 32'h2000_0FFC, 4'hF, 32'h0,         2,  1,  3, 1'b0, 32'h1111_1111};

    reset       = 1'b1;
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = 32'h0;
    bus.m_be    = 4'h0;
    bus.m_wdata = 32'h0;
    bus.s_ready = 4'h0;
    bus.s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hCAFE_F00D};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst s_cs_n", 32'(bus.s_cs_n), 32'hF);
    check("rst m_ready", 32'(bus.m_ready), 32'd0);
    check("rst m_err", 32'(bus.m_err), 32'd0);
    check("rst m_rdata", bus.m_rdata, 32'h0);
    check("rst s_we", 32'(bus.s_we), 32'd0);
    check("rst s_addr", bus.s_addr, 32'h0);
    check("rst s_be", 32'(bus.s_be), 32'd0);
    check("rst s_wdata", bus.s_wdata, 32'h0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    check("rst err_addr", err_addr, 32'h0);
    reset       = 1'b0;
    // Non-selected and idle ready lines are held high to show they are ignored.
    bus.s_ready = 4'hF;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset during the second wait cycle of an access to slave 1
    bus.m_req   = 1'b1;
    bus.m_we    = 1'b0;
    bus.m_addr  = 32'h2000_0010;
    bus.m_be    = 4'hF;
    bus.s_ready = 4'b1101;
    @(negedge clk);
    @(negedge clk);
    check("mid cs active", 32'(bus.s_cs_n), 32'hD);
    reset     = 1'b1;
    bus.m_req = 1'b0;
    @(negedge clk);
    check("mid cs released", 32'(bus.s_cs_n), 32'hF);
    check("mid no ready", 32'(bus.m_ready), 32'd0);
    reset       = 1'b0;
    bus.s_ready = 4'hF;
    model_cnt   = 0;
    model_addr  = 32'h0;
    pulses      = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.m_ready === 1'b1) pulses++;
    end
    check("mid stray pulses", 32'(pulses), 32'd0);
    check("mid err_cnt", 32'(err_cnt), 32'd0);
    run_vec(9, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus itself ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
